// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU bus responder.
// Region decode, DMA state codes and the fixed map boundaries.
package cpu_bus_pkg;

  typedef enum logic [2:0] {
    RGN_MEM,
    RGN_OAM,
    RGN_UNUSED,
    RGN_IO,
    RGN_HRAM,
    RGN_IE,
    RGN_DMAREG
  } region_t;

  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam logic [15:0] UNUSED_BASE  = 16'hFEA0;
  localparam logic [15:0] IO_BASE      = 16'hFF00;
  localparam logic [15:0] HRAM_BASE    = 16'hFF80;
  localparam logic [15:0] IE_ADDR      = 16'hFFFF;
  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [7:0]  OPEN_BUS     = 8'hFF;

  typedef logic [1:0] dma_state_t;
  localparam dma_state_t DMA_IDLE  = 2'd0;
  localparam dma_state_t DMA_START = 2'd1;
  localparam dma_state_t DMA_RD    = 2'd2;
  localparam dma_state_t DMA_WR    = 2'd3;

  // FF46 only leaves the I/O window when the DMA engine exists
  function automatic region_t decode(
    input logic [15:0] a,
    input logic        dma_en
  );
    if (a < OAM_BASE) return RGN_MEM;
    if (a < UNUSED_BASE) return RGN_OAM;
    if (a < IO_BASE) return RGN_UNUSED;
    if (a < HRAM_BASE)
      return (dma_en && a == DMA_REG_ADDR) ? RGN_DMAREG : RGN_IO;
    if (a == IE_ADDR) return RGN_IE;
    return RGN_HRAM;
  endfunction

endpackage

// File: rtl/cpu_bus_dma.sv
// OAM DMA engine: copies DMA_LEN bytes from {src,00h} into OAM,
// one read clock and one write clock per byte.
module cpu_bus_dma
  import cpu_bus_pkg::*;
#(
  parameter int DMA_LEN = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  src,
  input  logic [7:0]  mem_din,
  output logic        active,
  output logic [15:0] mem_a,
  output logic        mem_rd,
  output logic [7:0]  oam_a,
  output logic [7:0]  oam_dout,
  output logic        oam_wr
);

  localparam logic [7:0] LAST = 8'(DMA_LEN - 1);

  dma_state_t state;
  logic [7:0] src_q;
  logic [7:0] idx;
  logic [7:0] data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DMA_IDLE;
      src_q <= '0;
      idx   <= '0;
      data  <= '0;
    end else if (start) begin
      state <= DMA_START;
      src_q <= src;
      idx   <= '0;
    end else begin
      case (state)
        DMA_START: state <= DMA_RD;
        DMA_RD: begin
          data  <= mem_din;
          state <= DMA_WR;
        end
        DMA_WR: begin
          if (idx == LAST) begin
            state <= DMA_IDLE;
          end else begin
            idx   <= idx + 8'd1;
            state <= DMA_RD;
          end
        end
        default: state <= DMA_IDLE;
      endcase
    end
  end

  assign active   = (state != DMA_IDLE);
  assign mem_a    = {src_q, 8'h00} + {8'h00, idx};
  assign mem_rd   = (state == DMA_RD);
  assign oam_a    = idx;
  assign oam_dout = data;
  assign oam_wr   = (state == DMA_WR);

endmodule

// File: rtl/cpu_bus_target.sv
// CPU bus responder: decode, HRAM/IE, registered read data.
// OAM DMA engine present only when CPU_BUS_OAM_DMA_EN is defined.
module cpu_bus_target
  import cpu_bus_pkg::*;
#(
  parameter int DMA_LEN    = 160,
  parameter int HRAM_DEPTH = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [15:0] mem_a,
  output logic [7:0]  mem_dout,
  input  logic [7:0]  mem_din,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  oam_a,
  output logic [7:0]  oam_dout,
  input  logic [7:0]  oam_din,
  output logic        oam_rd,
  output logic        oam_wr,
  output logic [6:0]  io_a,
  output logic [7:0]  io_dout,
  input  logic [7:0]  io_din,
  output logic        io_rd,
  output logic        io_wr,
  output logic [7:0]  ie,
  output logic        dma_active
);

`ifdef CPU_BUS_OAM_DMA_EN
  localparam logic DMA_EN = 1'b1;
`else
  localparam logic DMA_EN = 1'b0;
`endif

  region_t sel;
  logic    rd;
  logic    wr;
  logic    lock;

  assign sel = decode(cpu_a, DMA_EN);
  // a simultaneous rd+wr is a write
  assign wr  = cpu_wr;
  assign rd  = cpu_rd & ~cpu_wr;

  logic [15:0] dma_mem_a;
  logic        dma_mem_rd;
  logic [7:0]  dma_oam_a;
  logic [7:0]  dma_oam_dout;
  logic        dma_oam_wr;
  logic [7:0]  dma_reg;

`ifdef CPU_BUS_OAM_DMA_EN
  logic dma_start;
  assign dma_start = wr && (sel == RGN_DMAREG);

  cpu_bus_dma #(
    .DMA_LEN(DMA_LEN)
  ) u_dma (
    .clk     (clk),
    .rst     (rst),
    .start   (dma_start),
    .src     (cpu_dout),
    .mem_din (mem_din),
    .active  (lock),
    .mem_a   (dma_mem_a),
    .mem_rd  (dma_mem_rd),
    .oam_a   (dma_oam_a),
    .oam_dout(dma_oam_dout),
    .oam_wr  (dma_oam_wr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dma_reg <= '0;
    else if (dma_start) dma_reg <= cpu_dout;
  end
`else
  assign lock         = 1'b0;
  assign dma_mem_a    = '0;
  assign dma_mem_rd   = 1'b0;
  assign dma_oam_a    = '0;
  assign dma_oam_dout = '0;
  assign dma_oam_wr   = 1'b0;
  assign dma_reg      = '0;
`endif

  assign dma_active = lock;

  // outputs forced low combinationally so reset acts without a clock
  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    oam_a    = '0;
    oam_dout = '0;
    oam_rd   = 1'b0;
    oam_wr   = 1'b0;
    io_a     = '0;
    io_dout  = '0;
    io_rd    = 1'b0;
    io_wr    = 1'b0;
    if (!rst) begin
      if (lock) begin
        mem_a    = dma_mem_a;
        mem_rd   = dma_mem_rd;
        oam_a    = dma_oam_a;
        oam_dout = dma_oam_dout;
        oam_wr   = dma_oam_wr;
      end else begin
        mem_a    = cpu_a;
        mem_dout = cpu_dout;
        mem_rd   = rd && (sel == RGN_MEM);
        mem_wr   = wr && (sel == RGN_MEM);
        oam_a    = cpu_a[7:0];
        oam_dout = cpu_dout;
        oam_rd   = rd && (sel == RGN_OAM);
        oam_wr   = wr && (sel == RGN_OAM);
      end
      io_a    = cpu_a[6:0];
      io_dout = cpu_dout;
      io_rd   = rd && (sel == RGN_IO);
      io_wr   = wr && (sel == RGN_IO);
    end
  end

  logic [7:0] hram [HRAM_DEPTH];
  logic [6:0] hidx;

  assign hidx = cpu_a[6:0];

  always_ff @(posedge clk) begin
    if (wr && sel == RGN_HRAM) hram[hidx] <= cpu_dout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ie <= '0;
    else if (wr && sel == RGN_IE) ie <= cpu_dout;
  end

  logic [7:0] rdata;

  always_comb begin
    rdata = 8'h00;
    unique case (sel)
      RGN_MEM:    rdata = lock ? OPEN_BUS : mem_din;
      RGN_OAM:    rdata = lock ? OPEN_BUS : oam_din;
      RGN_IO:     rdata = io_din;
      RGN_HRAM:   rdata = hram[hidx];
      RGN_IE:     rdata = ie;
      RGN_DMAREG: rdata = dma_reg;
      default:    rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cpu_din <= '0;
    else if (rd) cpu_din <= rdata;
  end

endmodule

// File: tb/tb_cpu_bus_target.sv
// Scoreboard bench for cpu_bus_target with a behavioural map model.
// Covers the DMA engine when CPU_BUS_OAM_DMA_EN is defined.
module tb_cpu_bus_target;

`ifdef CPU_BUS_OAM_DMA_EN
  localparam bit DMA_EN = 1'b1;
`else
  localparam bit DMA_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] cpu_a = '0;
  logic [7:0]  cpu_dout = '0;
  logic [7:0]  cpu_din;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [15:0] mem_a;
  logic [7:0]  mem_dout, mem_din;
  logic        mem_rd, mem_wr;
  logic [7:0]  oam_a, oam_dout, oam_din;
  logic        oam_rd, oam_wr;
  logic [6:0]  io_a;
  logic [7:0]  io_dout, io_din;
  logic        io_rd, io_wr;
  logic [7:0]  ie;
  logic        dma_active;

  always #5 clk = ~clk;

  function automatic logic [7:0] fmem(input logic [15:0] a);
    return a[15:8] ^ a[7:0] ^ 8'h92;
  endfunction

  function automatic logic [7:0] foam(input logic [7:0] a);
    return a ^ 8'h3C;
  endfunction

  function automatic logic [7:0] fio(input logic [6:0] a);
    return {1'b0, a} ^ 8'hA5;
  endfunction

  assign mem_din = fmem(mem_a);
  assign oam_din = foam(oam_a);
  assign io_din  = fio(io_a);

  cpu_bus_target dut (
    .clk(clk), .rst(rst),
    .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .mem_a(mem_a), .mem_dout(mem_dout), .mem_din(mem_din),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .oam_a(oam_a), .oam_dout(oam_dout), .oam_din(oam_din),
    .oam_rd(oam_rd), .oam_wr(oam_wr),
    .io_a(io_a), .io_dout(io_dout), .io_din(io_din),
    .io_rd(io_rd), .io_wr(io_wr),
    .ie(ie), .dma_active(dma_active)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] hram_m [127];
  logic [7:0] ie_m = '0;
  logic [7:0] dmareg_m = '0;
  logic [7:0] held = '0;
  logic [7:0] src_m = '0;
  int dma_start = 0;
  int dma_end = 0;
  logic [7:0] exp_q [$];
  int oamwr_seen = 0;
  int active_seen = 0;
  logic rd_q;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // 0 mem, 1 oam, 2 unused, 3 io, 4 hram, 5 ie, 6 dma register
  function automatic int region_of(input logic [15:0] a);
    if (a <= 16'hFDFF) return 0;
    if (a <= 16'hFE9F) return 1;
    if (a <= 16'hFEFF) return 2;
    if (a == 16'hFF46 && DMA_EN) return 6;
    if (a <= 16'hFF7F) return 3;
    if (a == 16'hFFFF) return 5;
    return 4;
  endfunction

  function automatic bit locked_m();
    return DMA_EN && cyc >= dma_start && cyc < dma_end;
  endfunction

  function automatic logic [7:0] model_read(input logic [15:0] a);
    case (region_of(a))
      0: return locked_m() ? 8'hFF : fmem(a);
      1: return locked_m() ? 8'hFF : foam(a[7:0]);
      2: return 8'h00;
      3: return fio(a[6:0]);
      4: return hram_m[a[6:0]];
      5: return ie_m;
      default: return dmareg_m;
    endcase
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [7:0] d);
    case (region_of(a))
      4: hram_m[a[6:0]] = d;
      5: ie_m = d;
      6: begin
        dmareg_m  = d;
        src_m     = d;
        dma_start = cyc + 1;
        dma_end   = cyc + 322;
      end
      default: ;
    endcase
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) rd_q <= 1'b0;
    else rd_q <= cpu_rd & ~cpu_wr;
  end

  int r_m, t_m;
  bit ro_m, wo_m;
  logic [7:0] e_m;

  always @(negedge clk) begin
    if (!rst) begin
      if (rd_q) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: read data with no expectation");
        end else begin
          e_m = exp_q.pop_front();
          held = e_m;
          chk("cpu_din", {24'h0, cpu_din}, {24'h0, e_m});
        end
      end else begin
        chk("cpu_din_hold", {24'h0, cpu_din}, {24'h0, held});
      end
      r_m  = region_of(cpu_a);
      ro_m = cpu_rd && !cpu_wr;
      wo_m = cpu_wr;
      chk("ie", {24'h0, ie}, {24'h0, ie_m});
      chk("dma_active", {31'h0, dma_active}, {31'h0, locked_m()});
      if (oam_wr) oamwr_seen++;
      if (dma_active) active_seen++;
      if (!locked_m()) begin
        chk("strobes", {26'h0, mem_rd, mem_wr, oam_rd, oam_wr, io_rd, io_wr},
            {26'h0, ro_m && r_m == 0, wo_m && r_m == 0, ro_m && r_m == 1,
             wo_m && r_m == 1, ro_m && r_m == 3, wo_m && r_m == 3});
        chk("port_addr", {1'b0, mem_a, oam_a, io_a},
            {1'b0, cpu_a, cpu_a[7:0], cpu_a[6:0]});
        chk("port_data", {8'h0, mem_dout, oam_dout, io_dout},
            {8'h0, cpu_dout, cpu_dout, cpu_dout});
      end else begin
        chk("locked_strobes", {28'h0, mem_wr, oam_rd, io_rd, io_wr},
            {30'h0, ro_m && r_m == 3, wo_m && r_m == 3});
        t_m = cyc - dma_start;
        if (t_m == 0) begin
          chk("dma_start_quiet", {30'h0, mem_rd, oam_wr}, 32'h0);
        end else if (t_m % 2 == 1) begin
          chk("dma_rd", {30'h0, mem_rd, oam_wr}, 32'h2);
          chk("dma_mem_a", {16'h0, mem_a},
              {16'h0, {src_m, 8'h00} + 16'((t_m - 1) / 2)});
        end else begin
          chk("dma_wr", {30'h0, mem_rd, oam_wr}, 32'h1);
          chk("dma_oam_a", {24'h0, oam_a}, 32'((t_m / 2) - 1));
          chk("dma_oam_dout", {24'h0, oam_dout},
              {24'h0, fmem({src_m, 8'h00} + 16'((t_m / 2) - 1))});
        end
      end
    end
  end

  task automatic acc(input logic w, input logic r, input logic [15:0] a,
                     input logic [7:0] d);
    @(posedge clk);
    #1;
    cpu_a    = a;
    cpu_dout = d;
    cpu_wr   = w;
    cpu_rd   = r;
    if (r && !w) exp_q.push_back(model_read(a));
    @(negedge clk);
    #1;
    if (w) model_write(a, d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cpu_rd = 1'b0;
      cpu_wr = 1'b0;
    end
  endtask

  task automatic rand_acc(input bit safe);
    int k, op;
    logic [15:0] a;
    logic w, r;
    k = $urandom_range(0, 5);
    case (k)
      0: a = 16'($urandom_range(0, 16'hFDFF));
      1: a = 16'hFE00 + 16'($urandom_range(0, 159));
      2: a = 16'hFEA0 + 16'($urandom_range(0, 95));
      3: begin
        a = 16'hFF00 + 16'($urandom_range(0, 127));
        if (a == 16'hFF46) a = 16'hFF47;
      end
      4: a = 16'hFF80 + 16'($urandom_range(0, 126));
      default: a = 16'hFFFF;
    endcase
    op = $urandom_range(0, 3);
    w = (op == 1 || op == 2);
    r = (op != 1);
    if (safe && k < 2) w = 1'b0;
    acc(w, r, a, 8'($urandom));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cpu_a = 16'h1234; cpu_dout = 8'hAA; cpu_rd = 1'b1; cpu_wr = 1'b1;
    #1 rst = 1'b1;
    #2;
    chk("rst_cpu_din", {24'h0, cpu_din}, 32'h0);
    chk("rst_ie", {24'h0, ie}, 32'h0);
    chk("rst_dma_active", {31'h0, dma_active}, 32'h0);
    chk("rst_strobes", {26'h0, mem_rd, mem_wr, oam_rd, oam_wr, io_rd, io_wr},
        32'h0);
    chk("rst_addr", {1'b0, mem_a, oam_a, io_a}, 32'h0);
    chk("rst_data", {8'h0, mem_dout, oam_dout, io_dout}, 32'h0);
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_a = '0; cpu_dout = '0;
    #9 rst = 1'b0;

    acc(1, 0, 16'hFF80, 8'h5A);
    acc(0, 1, 16'hFF80, 8'h00);
    acc(0, 1, 16'h0150, 8'h00);
    acc(1, 0, 16'hFEA0, 8'h11);
    acc(0, 1, 16'hFEA0, 8'h00);
    acc(1, 0, 16'hFFFF, 8'h9C);
    acc(0, 1, 16'hFFFF, 8'h00);
    acc(1, 1, 16'hFF80, 8'h77);
    acc(0, 1, 16'hFF80, 8'h00);
    acc(0, 1, 16'hFE9F, 8'h00);
    acc(0, 1, 16'hFF46, 8'h00);
    for (int i = 1; i < 127; i++) acc(1, 0, 16'hFF80 + 16'(i), 8'($urandom));
    repeat (300) rand_acc(1'b0);
    idle(2);

    oamwr_seen = 0;
    active_seen = 0;
    acc(1, 0, 16'hFF46, 8'hC1);
    acc(0, 1, 16'hFF46, 8'h00);
    idle(5);
    acc(0, 1, 16'hC000, 8'h00);
    acc(0, 1, 16'hFF80, 8'h00);
    acc(1, 0, 16'h8000, 8'h55);
    acc(0, 1, 16'hFE10, 8'h00);
    acc(1, 0, 16'hFF85, 8'h3E);
    acc(0, 1, 16'hFF85, 8'h00);
    repeat (100) rand_acc(1'b1);
    idle(250);
    chk("dma_active_cycles", 32'(active_seen), DMA_EN ? 32'd321 : 32'd0);
    chk("dma_oam_wr_count", 32'(oamwr_seen), DMA_EN ? 32'd160 : 32'd0);
    acc(0, 1, 16'hC000, 8'h00);

    acc(1, 0, 16'hFF46, 8'hD0);
    idle(40);
    acc(1, 0, 16'hFF46, 8'hE5);
    oamwr_seen = 0;
    active_seen = 0;
    idle(330);
    chk("restart_active_cycles", 32'(active_seen), DMA_EN ? 32'd321 : 32'd0);
    chk("restart_oam_wr_count", 32'(oamwr_seen), DMA_EN ? 32'd160 : 32'd0);

    acc(1, 0, 16'hFFFF, 8'h6B);
    acc(1, 0, 16'hFF46, 8'h7E);
    idle(41);
    @(negedge clk);
    #2;
    rst = 1'b1;
    dma_end = 0;
    ie_m = '0;
    dmareg_m = '0;
    held = '0;
    #1;
    chk("mid_rst_dma_active", {31'h0, dma_active}, 32'h0);
    chk("mid_rst_strobes", {30'h0, oam_wr, mem_rd}, 32'h0);
    chk("mid_rst_ie", {24'h0, ie}, 32'h0);
    chk("mid_rst_cpu_din", {24'h0, cpu_din}, 32'h0);
    chk("mid_rst_mem_a", {16'h0, mem_a}, 32'h0);
    @(negedge clk);
    #1 rst = 1'b0;
    acc(0, 1, 16'hFFFF, 8'h00);
    acc(0, 1, 16'hFF46, 8'h00);
    acc(0, 1, 16'hFF80, 8'h00);
    acc(0, 1, 16'hFF85, 8'h00);
    repeat (50) rand_acc(1'b0);
    idle(3);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_bus_target.md
# cpu_bus_target

Responder side of the CPU bus: accepts the CPU's address/data/rd/wr strobes and routes each access to the memory, OAM, or I/O ports, or to internal HRAM/IE. Returns registered read data with fixed one-clock latency. Contains the OAM DMA engine, which owns the memory and OAM ports during a transfer. Sits between `cpu` and the memory/PPU/peripheral fabric.

## Interface
- `DMA_LEN`, 160: bytes per OAM DMA transfer.
- `HRAM_DEPTH`, 127: HRAM bytes, mapped from FF80h.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `cpu_a`  in  16  CPU address.
- `cpu_dout`  in  8  CPU write data.
- `cpu_din`  out  8  read data to CPU.
- `cpu_rd` / `cpu_wr`  in  1  single-clock access strobes.
- `mem_a` / `mem_dout` / `mem_din` / `mem_rd` / `mem_wr`  out/out/in/out/out  16/8/8/1/1  port for 0000–FDFFh.
- `oam_a` / `oam_dout` / `oam_din` / `oam_rd` / `oam_wr`  out/out/in/out/out  8/8/8/1/1  port for FE00–FE9Fh.
- `io_a` / `io_dout` / `io_din` / `io_rd` / `io_wr`  out/out/in/out/out  7/8/8/1/1  port for FF00–FF7Fh; `io_a` is the offset.
- `ie`  out  8  IE register (FFFFh).
- `dma_active`  out  1  high while DMA owns the bus.

## Operation
- Address decode, combinational on `cpu_a`:
  - 0000–FDFF → mem.
  - FE00–FE9F → oam.
  - FEA0–FEFF → unusable: reads return 00h, writes dropped.
  - FF00–FF7F → io, except FF46.
  - FF80–FFFE → HRAM.
  - FFFF → IE.
- Port strobes follow `cpu_rd`/`cpu_wr` in the same clock. Address and write data pass through. Strobes are only asserted to the selected target.
- `cpu_rd` and `cpu_wr` high together: treated as a write. The read is ignored and `cpu_din` holds its value.
- Internal HRAM, IE and FF46 are written at the clock edge where `cpu_wr` is sampled high.
- FF46 read returns the last value written.
- DMA FSM:
  - States are IDLE → START → RD → WR → (RD … | IDLE).
  - A write to FF46 with value V latches source `{V,8'h00}`, clears the index, and enters START.
  - START lasts 1 clk.
  - RD: `mem_a`=src+idx, `mem_rd`=1; `mem_din` is captured at the end of the clock.
  - WR: `oam_a`=idx, `oam_dout`=captured byte, `oam_wr`=1, then idx+1.
  - After idx reaches `DMA_LEN`-1 and its WR completes, the FSM returns to IDLE.
  - `dma_active` is high in START/RD/WR.
- CPU access during DMA:
  - mem and oam reads return FFh; writes are dropped. No CPU strobe reaches these ports.
  - io, HRAM and IE behave normally.
- FF46 write while DMA is active: restarts from START with the new source and idx=0.
- Source is not remapped. V≥FEh drives `mem_a` as computed.

## Timing
- Read latency is 1 clk: `cpu_din` is registered from the selected source on the edge after `cpu_rd`.
- Write: the target sees the strobe in the same clk. Internal storage is updated at that edge.
- DMA total is 1 + 2·`DMA_LEN` clk from the FF46 write edge to IDLE (321 clk at default).
- Reset, effective immediately at any time including mid-DMA:
  - FSM goes to IDLE; `dma_active`=0.
  - `cpu_din`=00h, `ie`=00h, FF46 register=00h.
  - All rd/wr strobes are 0; all address/data outputs are 0.
  - HRAM contents are not reset.

## Configuration
- `CPU_BUS_OAM_DMA_EN` defined: DMA engine, FF46 register and bus lockout are present as above.
- Not defined:
  - FF46 is forwarded to the io port like any other I/O address.
  - `dma_active` is tied 0.
  - mem and oam ports are driven only by the CPU.
  - Read latency and the address map are otherwise unchanged.

## Structure
- `cpu_bus_pkg`:
  - region enum (MEM, OAM, UNUSED, IO, HRAM, IE, DMAREG);
  - region boundary constants;
  - DMA state enum;
  - `DMA_REG_ADDR`=FF46h;
  - `OPEN_BUS`=FFh.
- Sub-module `cpu_bus_dma`: FSM, source/index counters, OAM/mem port override muxing requests. Instantiated only under the macro.

## Test plan
- Write FF80=5Ah, then read FF80 → `cpu_din`=5Ah one clk after `cpu_rd`. No mem/io strobe.
- Read 0150h with `mem_din`=C3h → `mem_rd`=1 and `mem_a`=0150h in the same clk; `cpu_din`=C3h the next clk.
- Write FEA0h=11h, then read FEA0h → no port strobes; `cpu_din`=00h.
- Write FF46=C1h → `dma_active` for 321 clk. `mem_a` steps C100h…C19Fh. 160 `oam_wr` pulses with `oam_a` 00h…9Fh carrying the matching `mem_din` bytes.
- During DMA:
  - read C000h → `cpu_din`=FFh;
  - read FF80h → HRAM value;
  - write 8000h → no `mem_wr` from the CPU;
  - FF46 rewrite → idx restarts at 0.
- Assert `rst` mid-DMA → `dma_active`, `oam_wr` and `mem_rd` drop to 0 without waiting for a clock edge; `ie`=00h.
